// File: rtl/gf2_571_pkg.sv
// Shared constants and types for the GF(2^571) multiplier.
// The field polynomial is P(x) = x^571 + x^10 + x^5 + x^2 + 1.
package gf2_571_pkg;

   localparam int M = 571;

   // Reduction taps: x^571 == x^10 + x^5 + x^2 + 1
   localparam int TAP_A = 10;
   localparam int TAP_B = 5;
   localparam int TAP_C = 2;
   localparam int TAP_D = 0;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   function automatic int ndig(input int d);
      return (M + d - 1) / d;
   endfunction

endpackage

// File: rtl/gf2_571_digit_step.sv
// One Horner step: next_acc = (acc*x^D + a*dig) mod P, purely combinational.
// The overflow is at most D bits, so a single fold through the taps fully reduces it.
module gf2_571_digit_step
   import gf2_571_pkg::*;
#(
   parameter int D = 8
) (
   input  logic [M-1:0] acc,
   input  logic [M-1:0] a,
   input  logic [D-1:0] dig,
   output logic [M-1:0] next_acc
);

   logic [M+D-1:0] wide;
   logic [M-1:0]   hx;

   always_comb begin
      wide = {acc, {D{1'b0}}};
      for (int i = 0; i < D; i++) begin
         if (dig[i]) begin
            wide = wide ^ ({{D{1'b0}}, a} << i);
         end
      end
   end

   // Bits x^(571+j) fold back to x^j * (x^10 + x^5 + x^2 + 1)
   assign hx = M'(wide[M+D-1:M]);

   assign next_acc = wide[M-1:0] ^ (hx << TAP_A) ^ (hx << TAP_B)
                                 ^ (hx << TAP_C) ^ (hx << TAP_D);

endmodule

// File: rtl/gf2_mul_571_seq.sv
// Digit-serial GF(2^571) multiplier; result valid NDIG cycles after the accept edge.
// Result is held in DONE until out_ready; no operands are accepted until it is taken.
module gf2_mul_571_seq
   import gf2_571_pkg::*;
#(
   parameter int D = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [M-1:0] in_a,
   input  logic [M-1:0] in_b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [M-1:0] out_c,
   output logic         busy
);

   localparam int NDIG = ndig(D);
   localparam int BW   = NDIG * D;
   localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

   state_t        state;
   logic [M-1:0]  a_q;
   logic [BW-1:0] b_q;
   logic [M-1:0]  acc;
   logic [M-1:0]  next_acc;
   logic [CW-1:0] cnt;
   logic [D-1:0]  dig;

   // b is scanned most-significant digit first
   assign dig = b_q[int'(cnt)*D +: D];

   gf2_571_digit_step #(.D(D)) u_step (
      .acc      (acc),
      .a        (a_q),
      .dig      (dig),
      .next_acc (next_acc)
   );

   assign in_ready = (state == IDLE) && !rst;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_c     <= '0;
         acc       <= '0;
         cnt       <= '0;
         a_q       <= '0;
         b_q       <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_q   <= in_a;
                  b_q   <= BW'(in_b);
                  acc   <= '0;
                  cnt   <= CW'(NDIG - 1);
                  state <= RUN;
               end
            end
            RUN: begin
               acc <= next_acc;
               if (cnt == '0) begin
                  out_c     <= next_acc;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gf2_mul_571_seq.sv
// Directed bench for gf2_mul_571_seq at D=8, plus random checks at D=1 and D=32
// against a bit-serial reference multiplier.
module tb_gf2_mul_571_seq;

   localparam int M = 571;

   logic          clk = 1'b0;
   logic          rst;
   logic          out_ready;
   logic [M-1:0]  in_a, in_b;
   logic [2:0]    iv, ir, ov, bz;
   logic [M-1:0]  oc [3];
   int            nd [3];

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   gf2_mul_571_seq #(.D(8)) u_d8 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(in_a), .in_b(in_b),
      .out_valid(ov[0]), .out_ready(out_ready), .out_c(oc[0]), .busy(bz[0]));

   gf2_mul_571_seq #(.D(1)) u_d1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(in_a), .in_b(in_b),
      .out_valid(ov[1]), .out_ready(out_ready), .out_c(oc[1]), .busy(bz[1]));

   gf2_mul_571_seq #(.D(32)) u_d32 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(in_a), .in_b(in_b),
      .out_valid(ov[2]), .out_ready(out_ready), .out_c(oc[2]), .busy(bz[2]));

   task automatic chk(input string tag, input logic [M-1:0] obs, input logic [M-1:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: got %0d want %0d", tag, obs, exp);
      end
   endtask

   // Bit-serial shift-and-add reference, reducing one bit at a time
   function automatic logic [M-1:0] ref_mul(input logic [M-1:0] a, input logic [M-1:0] b);
      logic [M:0] r;
      r = '0;
      for (int i = M - 1; i >= 0; i--) begin
         r = {r[M-1:0], 1'b0};
         if (r[M]) begin
            r[M]  = 1'b0;
            r[10] = ~r[10];
            r[5]  = ~r[5];
            r[2]  = ~r[2];
            r[0]  = ~r[0];
         end
         if (b[i]) r[M-1:0] = r[M-1:0] ^ a;
      end
      return r[M-1:0];
   endfunction

   function automatic logic [M-1:0] rnd571();
      logic [575:0] w;
      for (int i = 0; i < 18; i++) w[i*32 +: 32] = $urandom;
      return w[M-1:0];
   endfunction

   function automatic logic [M-1:0] mono(input int e);
      logic [M-1:0] v;
      v = '0;
      v[e] = 1'b1;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Full operation on instance k; stall = cycles out_ready stays low once DONE is reached
   task automatic run_op(input int k, input logic [M-1:0] a, input logic [M-1:0] b,
                         input int stall, output logic [M-1:0] res, output int lat);
      int n;
      in_a = a;
      in_b = b;
      out_ready = (stall == 0);
      n = 0;
      while (!ir[k] && n < 1000) begin tick(); n++; end
      iv[k] = 1'b1;
      tick();
      iv[k] = 1'b0;
      in_a = rnd571();
      in_b = rnd571();
      lat = 0;
      while (!ov[k] && lat < 2000) begin tick(); lat++; end
      res = oc[k];
      repeat (stall) tick();
      out_ready = 1'b1;
      tick();
   endtask

   initial begin
      logic [M-1:0] res, exp, hold, b_r;
      int lat, n;
      logic seen;

      nd[0] = 72; nd[1] = 571; nd[2] = 18;
      rst = 1'b1; iv = '0; out_ready = 1'b1; in_a = '0; in_b = '0;
      repeat (3) tick();

      chki("reset_in_ready", 32'(ir[0]), 0);
      chki("reset_out_valid", 32'(ov), 0);
      chki("reset_busy", 32'(bz), 0);
      chk("reset_out_c", oc[0], '0);

      rst = 1'b0;
      #1;
      chki("idle_in_ready", 32'(ir[0]), 1);

      // a=1, b=1
      run_op(0, mono(0), mono(0), 0, res, lat);
      chk("one_times_one", res, mono(0));
      chki("one_latency", lat, 72);
      chki("one_valid_dropped", 32'(ov[0]), 0);
      chki("one_ready_after", 32'(ir[0]), 1);
      chk("one_out_c_held", oc[0], mono(0));

      // x^570 * x = x^571 = 0x425
      run_op(0, mono(570), mono(1), 0, res, lat);
      exp = '0; exp[10] = 1'b1; exp[5] = 1'b1; exp[2] = 1'b1; exp[0] = 1'b1;
      chk("single_fold", res, exp);

      // x^570 * x^570 = x^1140 = x^569 + x^18 + x^3 + x^2 + 1
      run_op(0, mono(570), mono(570), 0, res, lat);
      exp = '0; exp[569] = 1'b1; exp[18] = 1'b1; exp[3] = 1'b1; exp[2] = 1'b1; exp[0] = 1'b1;
      chk("double_fold", res, exp);

      // Backpressure: x^300 * x^300 = x^600 = x^39 + x^34 + x^31 + x^29
      exp = '0; exp[39] = 1'b1; exp[34] = 1'b1; exp[31] = 1'b1; exp[29] = 1'b1;
      in_a = mono(300); in_b = mono(300); out_ready = 1'b0;
      iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      lat = 0;
      while (!ov[0] && lat < 200) begin tick(); lat++; end
      chki("bp_latency", lat, 72);
      for (int c = 0; c < 10; c++) begin
         if (c == 4) begin iv[0] = 1'b1; in_a = mono(1); in_b = mono(1); end
         if (c == 5) iv[0] = 1'b0;
         chk("bp_out_c_stable", oc[0], exp);
         chki("bp_in_ready_low", 32'(ir[0]), 0);
         chki("bp_valid_held", 32'(ov[0]), 1);
         tick();
      end
      iv[0] = 1'b0;
      out_ready = 1'b1;
      tick();
      chki("bp_valid_fall", 32'(ov[0]), 0);
      chki("bp_in_ready_back", 32'(ir[0]), 1);
      repeat (3) tick();
      chki("bp_pulse_ignored", 32'(bz[0]), 0);
      chk("bp_out_c_kept", oc[0], exp);

      // Reset in the middle of RUN
      in_a = mono(570); in_b = mono(1);
      iv[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      repeat (30) tick();
      chki("mid_busy", 32'(bz[0]), 1);
      rst = 1'b1;
      #1;
      chki("rst_in_ready_low", 32'(ir[0]), 0);
      tick();
      rst = 1'b0;
      #1;
      chki("rst_valid_low", 32'(ov[0]), 0);
      chki("rst_in_ready_high", 32'(ir[0]), 1);
      chki("rst_busy_low", 32'(bz[0]), 0);
      seen = 1'b0;
      for (int c = 0; c < 80; c++) begin
         if (ov[0]) seen = 1'b1;
         tick();
      end
      chki("rst_no_result", 32'(seen), 0);
      b_r = rnd571();
      run_op(0, '0, b_r, 0, res, lat);
      chk("zero_operand", res, '0);
      chki("zero_latency", lat, 72);

      // Random pairs across digit widths, with random output stalls
      for (int i = 0; i < 12; i++) begin
         logic [M-1:0] ra, rb;
         ra = rnd571(); rb = rnd571();
         run_op(0, ra, rb, $urandom_range(0, 3), res, lat);
         chk("rand_d8", res, ref_mul(ra, rb));
         chki("rand_d8_lat", lat, nd[0]);
      end
      for (int i = 0; i < 12; i++) begin
         logic [M-1:0] ra, rb;
         ra = rnd571(); rb = rnd571();
         run_op(2, ra, rb, $urandom_range(0, 3), res, lat);
         chk("rand_d32", res, ref_mul(ra, rb));
         chki("rand_d32_lat", lat, nd[2]);
      end
      for (int i = 0; i < 2; i++) begin
         logic [M-1:0] ra, rb;
         ra = rnd571(); rb = rnd571();
         run_op(1, ra, rb, $urandom_range(0, 2), res, lat);
         chk("rand_d1", res, ref_mul(ra, rb));
         chki("rand_d1_lat", lat, nd[1]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
